// File: rtl/idli_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idli_pkg
// Description : Shared types for the nibble-serial datapath: operand slice
//               type, ALU opcode enum and opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_AND     = 4'd2,
        ALU_OR      = 4'd3,
        ALU_XOR     = 4'd4,
        ALU_ANDN    = 4'd5,
        ALU_CMP_EQ  = 4'd6,
        ALU_CMP_LT  = 4'd7,
        ALU_CMP_LTS = 4'd8
    } alu_op_t;

    // Compare ops produce only a flag, never write-back data.
    function automatic logic alu_op_is_cmp(input alu_op_t op);
        return (op == ALU_CMP_EQ) || (op == ALU_CMP_LT) || (op == ALU_CMP_LTS);
    endfunction

    // Ops that run through the adder with rhs inverted and carry-in 1.
    function automatic logic alu_op_is_sub(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_CMP_LT) || (op == ALU_CMP_LTS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idli_alu_slice_m.sv
`default_nettype none
// ============================================================================
// Module      : idli_alu_slice_m
// Description : Combinational 4-bit ALU slice; one nibble of a serial op.
// Revision    : 1.0 - initial release
// ============================================================================
module idli_alu_slice_m
    import idli_pkg::*;
(
    input  alu_op_t   i_op,
    input  sqi_data_t i_lhs,
    input  sqi_data_t i_rhs,
    input  logic      i_cin,
    output sqi_data_t o_result,
    output logic      o_cout,
    output logic      o_c3,
    output logic      o_eq
);

    sqi_data_t  w_b;
    logic [3:0] w_lo;
    logic [1:0] w_hi;
    sqi_data_t  w_sum;

    // Split the add at bit 3 so the carry into the sign bit is visible.
    always_comb begin
        w_b   = alu_op_is_sub(i_op) ? ~i_rhs : i_rhs;
        w_lo  = {1'b0, i_lhs[2:0]} + {1'b0, w_b[2:0]} + {3'b000, i_cin};
        w_hi  = {1'b0, i_lhs[3]} + {1'b0, w_b[3]} + {1'b0, w_lo[3]};
        w_sum = {w_hi[0], w_lo[2:0]};
    end

    always_comb begin
        o_result = i_lhs & i_rhs;
        case (i_op)
            ALU_ADD, ALU_SUB,
            ALU_CMP_LT, ALU_CMP_LTS: o_result = w_sum;
            ALU_OR:                  o_result = i_lhs | i_rhs;
            ALU_XOR:                 o_result = i_lhs ^ i_rhs;
            ALU_ANDN:                o_result = i_lhs & ~i_rhs;
            default:                 o_result = i_lhs & i_rhs;
        endcase
    end

    assign o_cout = w_hi[1];
    assign o_c3   = w_lo[3];
    assign o_eq   = (i_lhs == i_rhs);

endmodule
`default_nettype wire

// File: rtl/idli_alu_m.sv
`default_nettype none
// ============================================================================
// Module      : idli_alu_m
// Description : Nibble-serial 16-bit ALU, LSB nibble first, 4 cycles per op.
// Revision    : 1.0 - initial release
// ============================================================================
module idli_alu_m
    import idli_pkg::*;
(
    input  logic      i_alu_gck,
    input  logic      i_alu_rst_n,
    input  logic      i_alu_valid,
    input  alu_op_t   i_alu_op,
    input  sqi_data_t i_alu_lhs,
    input  sqi_data_t i_alu_rhs,
    output logic      o_alu_busy,
    output sqi_data_t o_alu_data,
    output logic      o_alu_data_vld,
    output logic      o_alu_flag,
    output logic      o_alu_flag_vld
);

    logic [1:0] r_cnt;
    alu_op_t    r_op;
    logic       r_carry;
    logic       r_eq;

    logic       w_idle;
    logic       w_active;
    alu_op_t    w_op;
    logic       w_cin;
    sqi_data_t  w_result;
    logic       w_cout;
    logic       w_c3;
    logic       w_eq;
    logic       w_flag;

    assign w_idle   = (r_cnt == 2'd0);
    assign w_active = !w_idle || i_alu_valid;
    assign w_op     = w_idle ? i_alu_op : r_op;
    assign w_cin    = w_idle ? alu_op_is_sub(i_alu_op) : r_carry;

    idli_alu_slice_m u_slice (
        .i_op     (w_op),
        .i_lhs    (i_alu_lhs),
        .i_rhs    (i_alu_rhs),
        .i_cin    (w_cin),
        .o_result (w_result),
        .o_cout   (w_cout),
        .o_c3     (w_c3),
        .o_eq     (w_eq)
    );

    // Only meaningful on nibble 3, where w_op already equals r_op.
    always_comb begin
        w_flag = 1'b0;
        case (w_op)
            ALU_CMP_EQ:  w_flag = r_eq & w_eq;
            ALU_CMP_LT:  w_flag = ~w_cout;
            ALU_CMP_LTS: w_flag = w_result[3] ^ w_c3 ^ w_cout;
            default:     w_flag = 1'b0;
        endcase
    end

    always_ff @(posedge i_alu_gck) begin
        if (!i_alu_rst_n) begin
            r_cnt          <= 2'd0;
            r_op           <= ALU_ADD;
            r_carry        <= 1'b0;
            r_eq           <= 1'b0;
            o_alu_data     <= '0;
            o_alu_data_vld <= 1'b0;
            o_alu_flag     <= 1'b0;
            o_alu_flag_vld <= 1'b0;
        end else begin
            o_alu_data_vld <= 1'b0;
            o_alu_flag_vld <= 1'b0;
            if (w_active) begin
                r_cnt   <= r_cnt + 2'd1;
                r_carry <= w_cout;
                r_eq    <= w_idle ? w_eq : (r_eq & w_eq);
                if (w_idle) begin
                    r_op <= i_alu_op;
                end
                if (!alu_op_is_cmp(w_op)) begin
                    o_alu_data     <= w_result;
                    o_alu_data_vld <= 1'b1;
                end
                if ((r_cnt == 2'd3) && alu_op_is_cmp(w_op)) begin
                    o_alu_flag     <= w_flag;
                    o_alu_flag_vld <= 1'b1;
                end
            end
        end
    end

    assign o_alu_busy = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_idli_alu_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_idli_alu_m
// Description : Scoreboard bench for idli_alu_m against a 16-bit word model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idli_alu_m;
    import idli_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ent_t;

    logic      gck;
    logic      rst_n;
    logic      valid;
    alu_op_t   op;
    sqi_data_t lhs;
    sqi_data_t rhs;
    logic      busy;
    sqi_data_t data;
    logic      data_vld;
    logic      flag;
    logic      flag_vld;

    int   cyc;
    int   errors;
    int   checks;
    logic exp_busy;
    logic rst_seen;
    logic mon_en;
    logic [3:0] last_data;
    logic last_flag;
    ent_t q_data[$];
    ent_t q_flag[$];

    idli_alu_m dut (
        .i_alu_gck      (gck),
        .i_alu_rst_n    (rst_n),
        .i_alu_valid    (valid),
        .i_alu_op       (op),
        .i_alu_lhs      (lhs),
        .i_alu_rhs      (rhs),
        .o_alu_busy     (busy),
        .o_alu_data     (data),
        .o_alu_data_vld (data_vld),
        .o_alu_flag     (flag),
        .o_alu_flag_vld (flag_vld)
    );

    initial gck = 1'b0;
    always #5 gck = ~gck;

    initial cyc = 0;
    always @(posedge gck) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Word-level reference: returns {is_cmp, flag, result}.
    function automatic logic [17:0] ref_model(input alu_op_t o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        f;
        logic        c;
        r = 16'h0; f = 1'b0; c = 1'b0;
        case (o)
            ALU_ADD:     r = a + b;
            ALU_SUB:     r = a - b;
            ALU_AND:     r = a & b;
            ALU_OR:      r = a | b;
            ALU_XOR:     r = a ^ b;
            ALU_ANDN:    r = a & ~b;
            ALU_CMP_EQ:  begin c = 1'b1; f = (a == b); end
            ALU_CMP_LT:  begin c = 1'b1; f = (a < b); end
            ALU_CMP_LTS: begin c = 1'b1; f = ($signed(a) < $signed(b)); end
            default:     r = a & b;
        endcase
        return {c, f, r};
    endfunction

    task automatic step();
        @(posedge gck);
        #1;
    endtask

    task automatic idle_cycle();
        valid    = 1'b0;
        op       = alu_op_t'(4'($urandom_range(0, 15)));
        lhs      = 4'($urandom);
        rhs      = 4'($urandom);
        exp_busy = 1'b0;
        step();
    endtask

    // Drives one 4-cycle op; nibbles_kept < 4 models an op cut short by reset.
    task automatic issue_op(input alu_op_t o, input logic [15:0] a, input logic [15:0] b,
                            input bit hold_valid, input int nibbles_kept);
        logic [17:0] m;
        int n;
        m = ref_model(o, a, b);
        n = cyc;
        if (m[17]) begin
            if (nibbles_kept == 4) q_flag.push_back('{n + 4, {3'b000, m[16]}});
        end else begin
            for (int k = 0; k < nibbles_kept; k++) q_data.push_back('{n + 1 + k, m[4*k +: 4]});
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                valid = 1'b1;
                op    = o;
            end else begin
                valid = hold_valid ? 1'b1 : 1'($urandom);
                op    = alu_op_t'(4'($urandom_range(0, 15)));
            end
            lhs      = a[4*k +: 4];
            rhs      = b[4*k +: 4];
            exp_busy = (k != 0);
            if (k == 2 && nibbles_kept < 4) rst_n = 1'b0;
            step();
            if (k == 2 && nibbles_kept < 4) begin
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    always @(negedge gck) begin
        if (mon_en) begin
            if (!rst_seen) begin
                chk("rst_busy", {15'b0, busy}, 16'h0);
                chk("rst_data", {12'b0, data}, 16'h0);
                chk("rst_data_vld", {15'b0, data_vld}, 16'h0);
                chk("rst_flag", {15'b0, flag}, 16'h0);
                chk("rst_flag_vld", {15'b0, flag_vld}, 16'h0);
                last_data = 4'h0;
                last_flag = 1'b0;
            end else begin
                chk("busy", {15'b0, busy}, {15'b0, exp_busy});
                while (q_data.size() > 0 && q_data[0].cyc < cyc) begin
                    chk("data_vld_missing", {15'b0, data_vld}, 16'h1);
                    void'(q_data.pop_front());
                end
                while (q_flag.size() > 0 && q_flag[0].cyc < cyc) begin
                    chk("flag_vld_missing", {15'b0, flag_vld}, 16'h1);
                    void'(q_flag.pop_front());
                end
                if (data_vld) begin
                    if (q_data.size() > 0 && q_data[0].cyc == cyc) begin
                        chk("data", {12'b0, data}, {12'b0, q_data[0].val});
                        void'(q_data.pop_front());
                    end else begin
                        chk("data_vld_unexpected", {15'b0, data_vld}, 16'h0);
                    end
                    last_data = data;
                end else begin
                    chk("data_hold", {12'b0, data}, {12'b0, last_data});
                end
                if (flag_vld) begin
                    if (q_flag.size() > 0 && q_flag[0].cyc == cyc) begin
                        chk("flag", {15'b0, flag}, {15'b0, q_flag[0].val[0]});
                        void'(q_flag.pop_front());
                    end else begin
                        chk("flag_vld_unexpected", {15'b0, flag_vld}, 16'h0);
                    end
                    last_flag = flag;
                end else begin
                    chk("flag_hold", {15'b0, flag}, {15'b0, last_flag});
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        errors    = 0;
        checks    = 0;
        mon_en    = 1'b0;
        rst_seen  = 1'b0;
        last_data = 4'h0;
        last_flag = 1'b0;
        exp_busy  = 1'b0;
        rst_n     = 1'b0;
        valid     = 1'b0;
        op        = ALU_ADD;
        lhs       = 4'h0;
        rhs       = 4'h0;
        step();
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;
        idle_cycle();

        issue_op(ALU_ADD, 16'h1234, 16'h0FFF, 1'b0, 4);
        idle_cycle();
        issue_op(ALU_SUB, 16'h0001, 16'h0002, 1'b0, 4);
        issue_op(ALU_SUB, 16'h8000, 16'h0001, 1'b0, 4);
        issue_op(ALU_CMP_LT, 16'h8000, 16'h0001, 1'b0, 4);
        idle_cycle();
        issue_op(ALU_CMP_LTS, 16'h8000, 16'h0001, 1'b0, 4);
        issue_op(ALU_CMP_LTS, 16'h0001, 16'h8000, 1'b0, 4);
        issue_op(ALU_CMP_EQ, 16'hABCD, 16'hABCD, 1'b0, 4);
        issue_op(ALU_CMP_EQ, 16'hABCD, 16'hABCE, 1'b0, 4);
        idle_cycle();
        issue_op(ALU_XOR, 16'hF0F0, 16'hFFFF, 1'b1, 4);
        issue_op(ALU_ANDN, 16'hFFFF, 16'h00FF, 1'b1, 4);
        idle_cycle();
        issue_op(alu_op_t'(4'd12), 16'hF0CC, 16'h3CAA, 1'b0, 4);
        issue_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 4);
        idle_cycle();

        issue_op(ALU_ADD, 16'h5555, 16'h1111, 1'b1, 2);
        issue_op(ALU_ADD, 16'h0001, 16'h0001, 1'b0, 4);

        for (int i = 0; i < 80; i++) begin
            int sel;
            alu_op_t ro;
            sel = $urandom_range(0, 9);
            ro  = (sel == 9) ? alu_op_t'(4'($urandom_range(9, 15))) : alu_op_t'(4'(sel));
            issue_op(ro, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                     1'($urandom), 4);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        wait_cyc = 0;
        while ((q_data.size() > 0 || q_flag.size() > 0) && wait_cyc < 10) begin
            idle_cycle();
            wait_cyc++;
        end
        idle_cycle();
        chk("pending_data", 16'(q_data.size()), 16'h0);
        chk("pending_flag", 16'(q_flag.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
